div_ratio_sched: RTL

// Scheduler for the selectable-ratio clock divider: drives its 2-bit ratio select from a queue of
// {ratio, hold} commands. Mirrors the divider period internally and changes the select only at

---
 rtl/div_ratio_sched_if.sv | 27 ++
 rtl/div_ratio_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div_ratio_sched_if.sv
// Command-side bundle of the divider ratio scheduler.
// The controller drives the master modport. The scheduler takes the slave modport.
interface div_ratio_sched_if #(
    parameter int unsigned HOLD_W = 8
);
    logic              req_valid;
    logic [1:0]        req_ratio;
    logic [HOLD_W-1:0] req_hold;
    logic              req_ready;
    logic              cmd_flush;

    modport master (
        output req_valid,
        output req_ratio,
        output req_hold,
        output cmd_flush,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_ratio,
        input  req_hold,
        input  cmd_flush,
        output req_ready
    );
endinterface

// File: rtl/div_ratio_sched.sv
// Ratio scheduler for the selectable-ratio clock divider: queues {ratio, hold} commands and
// switches the select only on mirrored output-period boundaries. Optional macro: SWITCH_CNT_EN.
module div_ratio_sched #(
    parameter int unsigned DEFAULT_RATIO = 0,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned HOLD_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    div_ratio_sched_if.slave     req_if,
    output logic [1:0]           x_out,
    output logic                 period_tick,
    output logic                 cmd_done,
    output logic                 busy
`ifdef SWITCH_CNT_EN
    ,
    output logic [15:0]          switch_count
`endif
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = 2 + HOLD_W;
    localparam logic [1:0]  DEF_X   = 2'(DEFAULT_RATIO);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          phase_cnt_q, phase_cnt_d;
    logic [1:0]          x_q, x_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                cmd_done_q, cmd_done_d;
    logic                flush_pend_q, flush_pend_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];

    logic [3:0]          period_last;
    logic                boundary;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic                can_pop;
    logic                flush_now;
    logic [1:0]          head_ratio;
    logic [HOLD_W-1:0]   head_hold;

    // ------------------------------------------------------------------
    // Divider period mirror: period is 2 << x clk cycles
    // ------------------------------------------------------------------
    always_comb begin
        period_last = 4'd1;
        case (x_q)
            2'd0:    period_last = 4'd1;
            2'd1:    period_last = 4'd3;
            2'd2:    period_last = 4'd7;
            default: period_last = 4'd15;
        endcase
    end

    assign boundary = (phase_cnt_q == period_last);

    always_comb begin
        phase_cnt_d = phase_cnt_q + 4'd1;
        if (boundary) begin
            phase_cnt_d = 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign flush_now  = req_if.cmd_flush;
    // A flush wins over a push landing on the same edge
    assign push       = req_if.req_valid && !full && !flush_now;
    assign can_pop    = !empty && !flush_now;
    assign head_ratio = mem_q[rd_ptr_q[AW-1:0]][ENTRY_W-1 -: 2];
    assign head_hold  = mem_q[rd_ptr_q[AW-1:0]][HOLD_W-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        if (flush_now) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {req_if.req_ratio, req_if.req_hold};
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM: every decision is gated by the period boundary
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        hold_cnt_d   = hold_cnt_q;
        cmd_done_d   = 1'b0;
        pop          = 1'b0;
        flush_pend_d = flush_pend_q || (flush_now && (state_q == ACTIVE));

        if (boundary) begin
            flush_pend_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (can_pop) begin
                        pop        = 1'b1;
                        x_d        = head_ratio;
                        hold_cnt_d = head_hold;
                        state_d    = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (flush_pend_q || flush_now) begin
                        cmd_done_d = 1'b1;
                        x_d        = DEF_X;
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end else if (hold_cnt_q == HOLD_W'(1)) begin
                        cmd_done_d = 1'b1;
                        // Chain straight into the next command with no default-ratio period
                        if (can_pop) begin
                            pop        = 1'b1;
                            x_d        = head_ratio;
                            hold_cnt_d = head_hold;
                        end else begin
                            x_d        = DEF_X;
                            hold_cnt_d = '0;
                            state_d    = IDLE;
                        end
                    end else if (hold_cnt_q == '0) begin
                        if (can_pop) begin
                            cmd_done_d = 1'b1;
                            pop        = 1'b1;
                            x_d        = head_ratio;
                            hold_cnt_d = head_hold;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
                default: begin
                    x_d        = DEF_X;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_cnt_q  <= 4'd0;
            x_q          <= DEF_X;
            hold_cnt_q   <= '0;
            cmd_done_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            phase_cnt_q  <= phase_cnt_d;
            x_q          <= x_d;
            hold_cnt_q   <= hold_cnt_d;
            cmd_done_q   <= cmd_done_d;
            flush_pend_q <= flush_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

`ifdef SWITCH_CNT_EN
    logic [15:0] switch_cnt_q, switch_cnt_d;

    always_comb begin
        switch_cnt_d = switch_cnt_q;
        if (boundary && (x_d != x_q) && (switch_cnt_q != 16'hFFFF)) begin
            switch_cnt_d = switch_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switch_cnt_q <= 16'd0;
        end else begin
            switch_cnt_q <= switch_cnt_d;
        end
    end

    assign switch_count = switch_cnt_q;
`endif

    assign x_out            = x_q;
    assign period_tick      = boundary;
    assign cmd_done         = cmd_done_q;
    assign busy             = (state_q == ACTIVE) || !empty;
    assign req_if.req_ready = !full;

endmodule
